// File: rtl/scan_display_ctrl_pkg.sv
// Shared constants and glyph table for the multiplexed 7-segment display path.
// Segment codes are active-low, bit order g..a.
package display_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int CODE_W       = 4;
  localparam int SEG_W        = 7;
  localparam int DEF_N_DIGITS = 8;
  localparam int DEF_IDX_W    = $clog2(DEF_N_DIGITS);
  localparam int PWM_W        = $clog2(16);

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0:    glyph = SEG_0;
      4'h1:    glyph = SEG_1;
      4'h2:    glyph = SEG_2;
      4'h3:    glyph = SEG_3;
      4'h4:    glyph = SEG_4;
      4'h5:    glyph = SEG_5;
      4'h6:    glyph = SEG_6;
      4'h7:    glyph = SEG_7;
      4'h8:    glyph = SEG_8;
      4'h9:    glyph = SEG_9;
      4'hA:    glyph = SEG_A;
      4'hB:    glyph = SEG_B;
      4'hC:    glyph = SEG_C;
      4'hD:    glyph = SEG_D;
      4'hE:    glyph = SEG_E;
      default: glyph = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/scan_display_ctrl_if.sv
// Display-side bundle: digit data and attributes in, anode/segment drive out.
// SCAN_DISPLAY_DIM_EN adds the 4-bit brightness input.
interface scan_display_ctrl_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic [N_DIGITS-1:0]   blink_in;
  logic [N_DIGITS-1:0]   A;
  logic [7:0]            C;
  logic                  frame_tick;
`ifdef SCAN_DISPLAY_DIM_EN
  logic [3:0]            bright;

  modport master (
    output digits_in, dp_in, blank_in, blink_in, bright,
    input  A, C, frame_tick
  );
  modport slave (
    input  digits_in, dp_in, blank_in, blink_in, bright,
    output A, C, frame_tick
  );
`else
  modport master (
    output digits_in, dp_in, blank_in, blink_in,
    input  A, C, frame_tick
  );
  modport slave (
    input  digits_in, dp_in, blank_in, blink_in,
    output A, C, frame_tick
  );
`endif
endinterface

// File: rtl/scan_display_ctrl_seg_decoder.sv
// Combinational 4-bit code to active-low g..a segment pattern.
module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  assign o_seg = glyph(i_code);

endmodule

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed common-anode 7-segment scan driver with guard time, frame snapshot and blink.
// Optional macro SCAN_DISPLAY_DIM_EN adds PWM brightness gating of the anodes.
module scan_display_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 63
) (
  input logic                clk,
  input logic                rst,
  scan_display_ctrl_if.slave io
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(N_DIGITS);
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0]  GUARD_V   = CNT_W'(GUARD);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [FCNT_W-1:0]     r_fcnt;
  logic                  r_bph;

  logic [4*N_DIGITS-1:0] r_dig;
  logic [N_DIGITS-1:0]   r_dp;
  logic [N_DIGITS-1:0]   r_blank;
  logic [N_DIGITS-1:0]   r_blink;

  logic [N_DIGITS-1:0]   r_A;
  logic [7:0]            r_C;
  logic                  r_tick;

  logic                  w_frame_start;
  logic                  w_slot_end;
  logic                  w_idx_last;
  logic [4*N_DIGITS-1:0] w_dig;
  logic [N_DIGITS-1:0]   w_dp_v;
  logic [N_DIGITS-1:0]   w_blank_v;
  logic [N_DIGITS-1:0]   w_blink_v;
  logic [3:0]            w_code;
  logic                  w_dp;
  logic                  w_blank;
  logic                  w_blink;
  logic [N_DIGITS-1:0]   w_sel;
  logic [6:0]            w_glyph;
  logic                  w_guard;
  logic                  w_dark;
  logic                  w_pwm_on;
  logic [N_DIGITS-1:0]   w_A_nxt;
  logic [7:0]            w_C_nxt;

  assign w_frame_start = (r_cnt == '0) && (r_idx == '0);
  assign w_slot_end    = (r_cnt == CNT_LAST);
  assign w_idx_last    = (r_idx == IDX_LAST);

  // Scan position: slot counter, digit index, frame counter and blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_fcnt <= '0;
      r_bph  <= 1'b0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      if (w_idx_last) begin
        r_idx <= '0;
        if (r_fcnt == FCNT_LAST) begin
          r_fcnt <= '0;
          r_bph  <= ~r_bph;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig   <= '0;
      r_dp    <= '0;
      r_blank <= '0;
      r_blink <= '0;
    end else if (w_frame_start) begin
      r_dig   <= io.digits_in;
      r_dp    <= io.dp_in;
      r_blank <= io.blank_in;
      r_blink <= io.blink_in;
    end
  end

  // The frame-start cycle reads the inputs directly so slot 0 already shows the new snapshot
  assign w_dig     = w_frame_start ? io.digits_in : r_dig;
  assign w_dp_v    = w_frame_start ? io.dp_in     : r_dp;
  assign w_blank_v = w_frame_start ? io.blank_in  : r_blank;
  assign w_blink_v = w_frame_start ? io.blink_in  : r_blink;

  always_comb begin
    w_code  = '0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    w_blink = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_code   = w_dig[4*i +: 4];
        w_dp     = w_dp_v[i];
        w_blank  = w_blank_v[i];
        w_blink  = w_blink_v[i];
        w_sel[i] = 1'b1;
      end
    end
  end

  seg_decoder u_seg_decoder (
    .i_code (w_code),
    .o_seg  (w_glyph)
  );

`ifdef SCAN_DISPLAY_DIM_EN
  logic [PWM_W-1:0] r_pwm;

  always_ff @(posedge clk) begin
    if (rst) r_pwm <= '0;
    else     r_pwm <= r_pwm + 1'b1;
  end

  assign w_pwm_on = (r_pwm <= io.bright);
`else
  assign w_pwm_on = 1'b1;
`endif

  assign w_guard = (r_cnt < GUARD_V);
  assign w_dark  = w_blank || (w_blink && r_bph);

  always_comb begin
    w_A_nxt = '1;
    w_C_nxt = 8'hFF;
    if (!w_guard && !w_dark) begin
      w_C_nxt = {~w_dp, w_glyph};
      if (w_pwm_on) w_A_nxt = ~w_sel;
    end
  end

  // Output register: one cycle behind the scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_A    <= '1;
      r_C    <= 8'hFF;
      r_tick <= 1'b0;
    end else begin
      r_A    <= w_A_nxt;
      r_C    <= w_C_nxt;
      r_tick <= w_frame_start;
    end
  end

  assign io.A          = r_A;
  assign io.C          = r_C;
  assign io.frame_tick = r_tick;

endmodule
